// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback around a mem_ready handshake.
module multicycle_controller #(
    parameter int ST_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] Alu_func,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_PC  = 4'd12,
        S_LUI      = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_MDR    = 2'b01;
    localparam logic [1:0] RS_ALU    = 2'b10;
    localparam logic [1:0] RS_IMM    = 2'b11;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_A     = 2'b10;

    localparam logic [1:0] SB_B   = 2'b00;
    localparam logic [1:0] SB_IMM = 2'b01;
    localparam logic [1:0] SB_4   = 2'b10;

    state_t     r_state;
    state_t     w_next;

    logic       r_fetch;
    logic       r_branch;
    logic       r_jmp;
    logic       r_adr;
    logic       r_mw;
    logic       r_rw;
    logic       r_ill;
    logic [1:0] r_rs;
    logic [1:0] r_sa;
    logic [1:0] r_sb;
    logic [2:0] r_alu;

    logic       w_is_r;
    logic       w_is_i;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_is_br;
    logic       w_is_jal;
    logic       w_is_jalr;
    logic       w_is_lui;

    logic       w_r_ok;
    logic       w_i_ok;
    logic       w_br_ok;
    logic       w_ls_ok;
    logic       w_jalr_ok;
    logic       w_taken;
    logic [2:0] w_r_alu;
    logic [2:0] w_i_alu;

    assign w_is_r    = (opcode == OP_R);
    assign w_is_i    = (opcode == OP_I);
    assign w_is_ld   = (opcode == OP_LD);
    assign w_is_st   = (opcode == OP_ST);
    assign w_is_br   = (opcode == OP_BR);
    assign w_is_jal  = (opcode == OP_JAL);
    assign w_is_jalr = (opcode == OP_JALR);
    assign w_is_lui  = (opcode == OP_LUI);

    // Only word loads/stores and plain jalr are implemented
    assign w_ls_ok   = (func3 == 3'b010);
    assign w_jalr_ok = (func3 == 3'b000);

    // R-type ALU op and legality from func7/func3
    always_comb begin
        w_r_alu = ALU_ADD;
        w_r_ok  = 1'b0;
        if (func7 == 7'h00) begin
            case (func3)
                3'b000: begin w_r_alu = ALU_ADD;  w_r_ok = 1'b1; end
                3'b010: begin w_r_alu = ALU_SLT;  w_r_ok = 1'b1; end
                3'b011: begin w_r_alu = ALU_SLTU; w_r_ok = 1'b1; end
                3'b110: begin w_r_alu = ALU_OR;   w_r_ok = 1'b1; end
                3'b111: begin w_r_alu = ALU_AND;  w_r_ok = 1'b1; end
                default: begin w_r_alu = ALU_ADD; w_r_ok = 1'b0; end
            endcase
        end else if (func7 == 7'h20 && func3 == 3'b000) begin
            w_r_alu = ALU_SUB;
            w_r_ok  = 1'b1;
        end
    end

    // I-type ALU op and legality from func3
    always_comb begin
        w_i_alu = ALU_ADD;
        w_i_ok  = 1'b1;
        case (func3)
            3'b000: w_i_alu = ALU_ADD;
            3'b010: w_i_alu = ALU_SLT;
            3'b011: w_i_alu = ALU_SLTU;
            3'b100: w_i_alu = ALU_XOR;
            3'b110: w_i_alu = ALU_OR;
            default: w_i_ok = 1'b0;
        endcase
    end

    // Branch condition from the A-B subtraction flags
    always_comb begin
        w_taken = 1'b0;
        w_br_ok = 1'b1;
        case (func3)
            3'b000: w_taken = zero;
            3'b001: w_taken = !zero;
            3'b100: w_taken = sign;
            3'b101: w_taken = !sign || zero;
            default: w_br_ok = 1'b0;
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        ImmSrc = 3'b000;
        unique case (1'b1)
            w_is_st:  ImmSrc = 3'b001;
            w_is_br:  ImmSrc = 3'b010;
            w_is_lui: ImmSrc = 3'b011;
            w_is_jal: ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_is_ld && w_ls_ok:     w_next = S_MEM_ADR;
                    w_is_st && w_ls_ok:     w_next = S_MEM_ADR;
                    w_is_r && w_r_ok:       w_next = S_EXEC_R;
                    w_is_i && w_i_ok:       w_next = S_EXEC_I;
                    w_is_br && w_br_ok:     w_next = S_BRANCH;
                    w_is_jal:               w_next = S_JAL;
                    w_is_jalr && w_jalr_ok: w_next = S_JALR_ADR;
                    w_is_lui:               w_next = S_LUI;
                    default:                w_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR:  w_next = w_is_st ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC_R:   w_next = S_ALU_WB;
            S_EXEC_I:   w_next = S_ALU_WB;
            S_ALU_WB:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALU_WB;
            S_JALR_ADR: w_next = S_JALR_PC;
            S_JALR_PC:  w_next = S_ALU_WB;
            S_LUI:      w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // State register; per-state outputs are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_fetch  <= 1'b1;
            r_branch <= 1'b0;
            r_jmp    <= 1'b0;
            r_adr    <= 1'b0;
            r_mw     <= 1'b0;
            r_rw     <= 1'b0;
            r_ill    <= 1'b0;
            r_rs     <= RS_ALU;
            r_sa     <= SA_PC;
            r_sb     <= SB_4;
            r_alu    <= ALU_ADD;
        end else begin
            r_state  <= w_next;
            r_fetch  <= 1'b0;
            r_branch <= 1'b0;
            r_jmp    <= 1'b0;
            r_adr    <= 1'b0;
            r_mw     <= 1'b0;
            r_rw     <= 1'b0;
            r_ill    <= 1'b0;
            r_rs     <= RS_ALUOUT;
            r_sa     <= SA_PC;
            r_sb     <= SB_B;
            r_alu    <= ALU_ADD;
            unique case (w_next)
                S_FETCH: begin
                    r_fetch <= 1'b1;
                    r_rs    <= RS_ALU;
                    r_sb    <= SB_4;
                end
                S_DECODE: begin
                    r_sa <= SA_OLDPC;
                    r_sb <= SB_IMM;
                end
                S_MEM_ADR, S_JALR_ADR: begin
                    r_sa <= SA_A;
                    r_sb <= SB_IMM;
                end
                S_MEM_RD: r_adr <= 1'b1;
                S_MEM_WB: begin
                    r_rs <= RS_MDR;
                    r_rw <= 1'b1;
                end
                S_MEM_WR: begin
                    r_adr <= 1'b1;
                    r_mw  <= 1'b1;
                end
                S_EXEC_R: begin
                    r_sa  <= SA_A;
                    r_alu <= w_r_alu;
                end
                S_EXEC_I: begin
                    r_sa  <= SA_A;
                    r_sb  <= SB_IMM;
                    r_alu <= w_i_alu;
                end
                S_ALU_WB: r_rw <= 1'b1;
                S_BRANCH: begin
                    r_branch <= 1'b1;
                    r_sa     <= SA_A;
                    r_alu    <= ALU_SUB;
                end
                S_JAL, S_JALR_PC: begin
                    r_jmp <= 1'b1;
                    r_sa  <= SA_OLDPC;
                    r_sb  <= SB_4;
                end
                S_LUI: begin
                    r_rs <= RS_IMM;
                    r_rw <= 1'b1;
                end
                S_ILLEGAL: r_ill <= 1'b1;
                default: r_fetch <= 1'b0;
            endcase
        end
    end

    // Enables are blocked while reset is asserted; fetch/branch terms are Mealy
    always_comb begin
        PCWrite   = !rst && ((r_fetch && mem_ready) || r_jmp ||
                             (r_branch && w_taken));
        IRWrite   = !rst && r_fetch && mem_ready;
        MemWrite  = !rst && r_mw;
        RegWrite  = !rst && r_rw;
        illegal   = !rst && r_ill;
        AdrSrc    = r_adr;
        ResultSrc = r_rs;
        ALUSrcA   = r_sa;
        ALUSrcB   = r_sb;
        Alu_func  = r_alu;
    end

endmodule
